status_collector: RTL

Buffers the per-instruction status codes emitted by `core` (`o_status`/`o_status_valid`) and hands them to a downstream reader (checker, host port) through a valid/ready interface. It sits directly downstream of the core's status output. It stops capturing after the first terminal code (INVALID or EOF) and counts accepted codes. It reports completion once the terminal code has been drained.

---
 rtl/status_pkg.sv | 16 +
 rtl/status_fifo.sv | 55 +++++
 rtl/status_collector.sv | 92 +++++++++
 3 files changed

// File: rtl/status_pkg.sv
// Shared status-code definitions for the core, the collector and benches.
// Holds the code width, terminal codes and the collector state encoding.
package status_pkg;

  localparam int STAT_W = 3;

  localparam logic [STAT_W-1:0] INVALID_CODE = 3'd5;
  localparam logic [STAT_W-1:0] EOF_CODE     = 3'd6;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/status_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit.
// Head is shown only while non-empty so the read port idles at zero.
module status_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the head slot on the same edge, so full+pop may push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_collector.sv
// Buffers core status codes for a valid/ready reader, stops after the
// first terminal code and reports done once that code has drained.
module status_collector #(
  parameter int                     DEPTH        = 8,
  parameter int                     STAT_W       = status_pkg::STAT_W,
  parameter int                     CNT_W        = 16,
  parameter logic [STAT_W-1:0]      INVALID_CODE = status_pkg::INVALID_CODE,
  parameter logic [STAT_W-1:0]      EOF_CODE     = status_pkg::EOF_CODE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [STAT_W-1:0] i_status,
  input  logic              i_status_valid,
  output logic [STAT_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_halted,
  output logic              o_done,
  output logic              o_overflow
);

  import status_pkg::*;

  state_t state_q;
  state_t state_d;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;
  logic   term;

  assign push = i_status_valid && (state_q == RUN);
  assign pop  = o_rd_valid && i_rd_ready;
  assign term = (i_status == INVALID_CODE) ||
                (i_status == EOF_CODE);

  assign o_rd_valid = !empty;

  status_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (STAT_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_status),
    .rdata (o_rd_data),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push && term) state_d = HALT;
      HALT:    if (empty)        state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    o_halted = (state_q != RUN);
    o_done   = (state_q == DONE);
  end

  // Dropped codes still count; only the FIFO entry is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (push) begin
      if (o_count != '1) begin
        o_count <= o_count + 1'b1;
      end
      if (full && !pop) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule
